spi_regmap_burst: RTL

Parametrised successor to the single-access SPI register map. It combines an oversampled SPI mode-0 slave with a config/status register file, and runs entirely in the clk_i domain with a synchronous active-high reset. New over the previous generation:
- multi-word burst access with address auto-increment and wrap
- coherent status snapshot taken at frame start
- read-only and unmapped address protection
- per-write strobe output
- aborted-frame reporting

---
 rtl/spi_regmap_burst_if.sv | 29 ++
 rtl/spi_regmap_burst.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regmap_burst_if.sv
// Bus bundle for spi_regmap_burst: SPI pins, config/status buses and
// write/abort notifications. The register map is the slave side.
interface spi_regmap_burst_if #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CONFIG_REG = 96,
    parameter int NUM_STATUS_REG = 32
);
    logic                                 sck_i;
    logic                                 sdi_i;
    logic                                 cs_ni;
    logic                                 sdo_o;
    logic                                 sdo_oe_o;
    logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] config_bus_o;
    logic [DATA_WIDTH*NUM_STATUS_REG-1:0] status_bus_i;
    logic                                 wr_strobe_o;
    logic [ADDR_WIDTH-1:0]                wr_addr_o;
    logic                                 abort_o;

    modport slave (
        input  sck_i, sdi_i, cs_ni, status_bus_i,
        output sdo_o, sdo_oe_o, config_bus_o, wr_strobe_o, wr_addr_o, abort_o
    );

    modport master (
        output sck_i, sdi_i, cs_ni, status_bus_i,
        input  sdo_o, sdo_oe_o, config_bus_o, wr_strobe_o, wr_addr_o, abort_o
    );
endinterface

// File: rtl/spi_regmap_burst.sv
// Oversampled SPI mode-0 slave with a burst-capable config/status register
// map. Everything runs on clk_i; SPI pins are synchronised and edge-detected.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | CS deasserted; waiting for CS fall, status snapshot taken then
// S_INST  | waiting for the first SCK rise (instruction bit)
// S_ADDR  | shifting in the address field
// S_WDATA | shifting in write words, committing each one as it completes
// S_RDATA | shifting out read words from the auto-incrementing address
module spi_regmap_burst #(
    parameter int                    ADDR_WIDTH     = 7,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    NUM_CONFIG_REG = 96,
    parameter int                    NUM_STATUS_REG = 32,
    parameter logic [DATA_WIDTH-1:0] CONFIG_RESET   = '0,
    parameter int                    SYNC_STAGES    = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    spi_regmap_burst_if.slave bus
);

    localparam int LP_NUM_REGS   = NUM_CONFIG_REG + NUM_STATUS_REG;
    localparam int LP_SHIFT_W    = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int LP_CNT_W      = $clog2(LP_SHIFT_W + 1);
    localparam int LP_CFG_IDX_W  = (NUM_CONFIG_REG > 1) ? $clog2(NUM_CONFIG_REG) : 1;
    localparam int LP_STS_IDX_W  = (NUM_STATUS_REG > 1) ? $clog2(NUM_STATUS_REG) : 1;

    localparam logic [ADDR_WIDTH:0]   LP_CFG_END   = (ADDR_WIDTH+1)'(NUM_CONFIG_REG);
    localparam logic [ADDR_WIDTH:0]   LP_REG_END   = (ADDR_WIDTH+1)'(LP_NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(LP_NUM_REGS - 1);
    localparam logic [LP_CNT_W-1:0]   LP_ADDR_BITS = LP_CNT_W'(ADDR_WIDTH);
    localparam logic [LP_CNT_W-1:0]   LP_DATA_LAST = LP_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INST  = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sck_prev;
    logic                   r_cs_prev;

    logic [DATA_WIDTH-1:0]  r_config [NUM_CONFIG_REG];
    logic [DATA_WIDTH-1:0]  r_snap   [NUM_STATUS_REG];
    logic [LP_SHIFT_W-2:0]  r_shift;
    logic [LP_CNT_W-1:0]    r_bit_cnt;
    logic                   r_write;
    logic [ADDR_WIDTH-1:0]  r_cur_addr;
    logic [DATA_WIDTH-1:0]  r_tx;
    logic                   r_wr_strobe;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic                   r_abort;

    logic                   w_sck;
    logic                   w_sdi;
    logic                   w_cs_n;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic [ADDR_WIDTH-1:0]  w_addr_word;
    logic [DATA_WIDTH-1:0]  w_data_word;
    logic                   w_hdr_done;
    logic                   w_word_done;
    logic [ADDR_WIDTH-1:0]  w_addr_inc;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;
    logic [DATA_WIDTH-1:0]  w_rd_word;
    logic                   w_cfg_hit;
    logic                   w_sdo;
    logic                   w_sdo_oe;

    // Synchronise the SPI pins and keep the previous synced value for edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck_sync <= '0;
            r_sdi_sync <= '0;
            r_cs_sync  <= '0;
            r_sck_prev <= 1'b0;
            r_cs_prev  <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck_i};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], bus.sdi_i};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_ni};
            r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
            r_cs_prev  <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
    assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign w_cs_fall  = ~w_cs_n & r_cs_prev;
    assign w_cs_rise  = w_cs_n & ~r_cs_prev;

    // The bit arriving on this rise completes the address/data word.
    assign w_addr_word = {r_shift[ADDR_WIDTH-2:0], w_sdi};
    assign w_data_word = {r_shift[DATA_WIDTH-2:0], w_sdi};
    assign w_hdr_done  = w_sck_rise && (r_state == S_ADDR) && (r_bit_cnt == LP_ADDR_BITS);
    assign w_word_done = w_sck_rise && ((r_state == S_WDATA) || (r_state == S_RDATA))
                         && (r_bit_cnt == LP_DATA_LAST);
    assign w_addr_inc  = (r_cur_addr == LP_LAST_ADDR) ? '0 : r_cur_addr + ADDR_WIDTH'(1);
    assign w_cfg_hit   = {1'b0, r_cur_addr} < LP_CFG_END;

    // First word of a read comes from the fresh address, later ones from the next address.
    assign w_rd_addr   = (r_state == S_ADDR) ? w_addr_word : w_addr_inc;

    // Read word lookup: config, frozen snapshot, or zero for unmapped space.
    always_comb begin
        w_rd_word = '0;
        if ({1'b0, w_rd_addr} < LP_CFG_END) begin
            w_rd_word = r_config[LP_CFG_IDX_W'(w_rd_addr)];
        end else if ({1'b0, w_rd_addr} < LP_REG_END) begin
            w_rd_word = r_snap[LP_STS_IDX_W'(w_rd_addr - ADDR_WIDTH'(NUM_CONFIG_REG))];
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; CS deassertion returns to idle from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall)  w_state_nxt = S_INST;
            S_INST:  if (w_sck_rise) w_state_nxt = S_ADDR;
            S_ADDR:  if (w_hdr_done) w_state_nxt = r_write ? S_WDATA : S_RDATA;
            default: w_state_nxt = r_state;
        endcase
        if (w_cs_rise) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Output drive: SDO only during the read data phase, dropped on the CS rise cycle.
    always_comb begin
        w_sdo_oe = (r_state == S_RDATA) && !w_cs_rise;
        w_sdo    = w_sdo_oe & r_tx[DATA_WIDTH-1];
    end

    // Shifting, address tracking, register writes, snapshot and abort reporting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CONFIG_REG; k++) r_config[k] <= CONFIG_RESET;
            for (int k = 0; k < NUM_STATUS_REG; k++) r_snap[k] <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_write     <= 1'b0;
            r_cur_addr  <= '0;
            r_tx        <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_abort     <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_abort     <= 1'b0;
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
                if (w_cs_fall) begin
                    for (int k = 0; k < NUM_STATUS_REG; k++)
                        r_snap[k] <= bus.status_bus_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end else if (w_sck_rise) begin
                r_shift <= {r_shift[LP_SHIFT_W-3:0], w_sdi};
                case (r_state)
                    S_INST: begin
                        r_write   <= w_sdi;
                        r_bit_cnt <= LP_CNT_W'(1);
                    end
                    S_ADDR: begin
                        if (w_hdr_done) begin
                            r_bit_cnt  <= '0;
                            r_cur_addr <= w_addr_word;
                            r_tx       <= w_rd_word;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + LP_CNT_W'(1);
                        end
                    end
                    S_WDATA: begin
                        if (w_word_done) begin
                            r_bit_cnt  <= '0;
                            r_cur_addr <= w_addr_inc;
                            if (w_cfg_hit) begin
                                r_config[LP_CFG_IDX_W'(r_cur_addr)] <= w_data_word;
                                r_wr_strobe <= 1'b1;
                                r_wr_addr   <= r_cur_addr;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + LP_CNT_W'(1);
                        end
                    end
                    S_RDATA: begin
                        if (w_word_done) begin
                            r_bit_cnt  <= '0;
                            r_cur_addr <= w_addr_inc;
                            r_tx       <= w_rd_word;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + LP_CNT_W'(1);
                        end
                    end
                    default: r_bit_cnt <= r_bit_cnt;
                endcase
            end else if (w_sck_fall && (r_state == S_RDATA) && (r_bit_cnt != '0)) begin
                // A zero count means a word was just loaded; its MSB must stay put.
                r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            end
            if (w_cs_rise && (r_state != S_IDLE)) begin
                r_bit_cnt <= '0;
                r_abort   <= (r_bit_cnt != '0) && !w_hdr_done && !w_word_done;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CONFIG_REG; g++) begin : g_cfg_bus
            assign bus.config_bus_o[g*DATA_WIDTH +: DATA_WIDTH] = r_config[g];
        end
    endgenerate

    assign bus.sdo_o       = w_sdo;
    assign bus.sdo_oe_o    = w_sdo_oe;
    assign bus.wr_strobe_o = r_wr_strobe;
    assign bus.wr_addr_o   = r_wr_addr;
    assign bus.abort_o     = r_abort;

endmodule
